// File: rtl/ring_lock_pkg.sv
// Shared types and constants for the ring heater lock controller and its measurement unit.
package ring_lock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_TRACK_CENTER,
    ST_TRACK_TRIAL,
    ST_DECIDE
  } state_e;

  typedef enum logic [1:0] {
    MS_IDLE,
    MS_SETTLE,
    MS_ACC,
    MS_DONE
  } meas_state_e;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_e;

  localparam int unsigned      SAT_W   = 2;
  localparam logic [SAT_W-1:0] SAT_MAX = SAT_W'(2);

  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v);
    return (v == SAT_MAX) ? v : v + SAT_W'(1);
  endfunction

endpackage

// File: rtl/ring_lock_meas.sv
// Settle-then-average measurement unit: waits SETTLE_CYCLES after start, then averages
// 2^AVG_LOG2 valid photodetector samples. done is a single-cycle pulse with result valid.
module ring_lock_meas
  import ring_lock_pkg::*;
#(
  parameter int unsigned PD_W          = 12,
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned AVG_LOG2      = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            pd_valid,
  input  logic [PD_W-1:0] pd_sample,
  output logic            done,
  output logic [PD_W-1:0] result
);
  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned CNT_W = AVG_LOG2 + 1;
  localparam int unsigned ACC_W = PD_W + AVG_LOG2;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  meas_state_e      ph_q, ph_d;
  logic [SET_W-1:0] set_q, set_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q  <= MS_IDLE;
      set_q <= '0;
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      ph_q  <= ph_d;
      set_q <= set_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

  // Samples offered during MS_DONE are dropped: the average is already complete.
  always_comb begin
    ph_d  = ph_q;
    set_d = set_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (abort) begin
      ph_d  = MS_IDLE;
      set_d = '0;
      cnt_d = '0;
      acc_d = '0;
    end else if (start) begin
      ph_d  = MS_SETTLE;
      set_d = '0;
      cnt_d = '0;
      acc_d = '0;
    end else begin
      case (ph_q)
        MS_SETTLE: begin
          if (set_q == SET_LAST) ph_d = MS_ACC;
          else                   set_d = set_q + SET_W'(1);
        end
        MS_ACC: begin
          if (pd_valid) begin
            acc_d = acc_q + ACC_W'(pd_sample);
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) ph_d = MS_DONE;
          end
        end
        MS_DONE: ph_d = MS_IDLE;
        default: ;
      endcase
    end
  end

  assign done   = (ph_q == MS_DONE);
  assign result = acc_q[ACC_W-1:AVG_LOG2];

endmodule

// File: rtl/ring_heater_lock_ctrl.sv
// Ring-modulator heater lock loop: optional coarse sweep, then hill-climb minimising thru-port power.
// Define RING_LOCK_SWEEP_EN to include the coarse sweep; otherwise tracking starts at INIT_CODE.
module ring_heater_lock_ctrl
  import ring_lock_pkg::*;
#(
  parameter int unsigned HEATER_W      = 10,
  parameter int unsigned PD_W          = 12,
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned AVG_LOG2      = 2,
  parameter int unsigned COARSE_STEP   = 16,
  parameter int unsigned INIT_CODE     = 512
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                pd_valid,
  input  logic [PD_W-1:0]     pd_sample,
  output logic [HEATER_W-1:0] heater_code,
  output logic                locked,
  output logic                busy
);
  localparam logic [HEATER_W-1:0] INIT_VAL = HEATER_W'(INIT_CODE);

  if (SETTLE_CYCLES < 1 || COARSE_STEP < 1) begin : g_param_check
    $error("ring_heater_lock_ctrl: SETTLE_CYCLES and COARSE_STEP must be >= 1");
  end

  state_e              state_q, state_d;
  dir_e                dir_q, dir_d;
  logic [HEATER_W-1:0] heater_q, heater_d;
  logic [HEATER_W-1:0] center_q, center_d;
  logic                locked_q, locked_d;
  logic                busy_q, busy_d;
  logic                skip_q, skip_d;
  logic [SAT_W-1:0]    rev_q, rev_d;
  logic [SAT_W-1:0]    move_q, move_d;
  logic [PD_W-1:0]     pc_q, pc_d;
  logic [PD_W-1:0]     pt_q, pt_d;

  logic                meas_start, meas_abort, meas_done;
  logic [PD_W-1:0]     meas_result;
  logic                trial_ok;
  logic [HEATER_W-1:0] trial_code;

`ifdef RING_LOCK_SWEEP_EN
  localparam logic [31:0] HEATER_MAX = 32'((1 << HEATER_W) - 1);
  logic [HEATER_W-1:0] best_code_q, best_code_d;
  logic [PD_W-1:0]     best_p_q, best_p_d;
  logic [31:0]         sweep_next;
  assign sweep_next = 32'(heater_q) + 32'(COARSE_STEP);
`endif

  ring_lock_meas #(
    .PD_W         (PD_W),
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .AVG_LOG2     (AVG_LOG2)
  ) u_meas (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (meas_start),
    .abort    (meas_abort),
    .pd_valid (pd_valid),
    .pd_sample(pd_sample),
    .done     (meas_done),
    .result   (meas_result)
  );

  // A step off either end of the code range is treated as a worse trial, never driven.
  always_comb begin
    if (dir_q == DIR_UP) begin
      trial_ok   = (heater_q != '1);
      trial_code = heater_q + HEATER_W'(1);
    end else begin
      trial_ok   = (heater_q != '0);
      trial_code = heater_q - HEATER_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      dir_q       <= DIR_UP;
      heater_q    <= INIT_VAL;
      center_q    <= INIT_VAL;
      locked_q    <= 1'b0;
      busy_q      <= 1'b0;
      skip_q      <= 1'b0;
      rev_q       <= '0;
      move_q      <= '0;
      pc_q        <= '0;
      pt_q        <= '0;
`ifdef RING_LOCK_SWEEP_EN
      best_code_q <= '0;
      best_p_q    <= '1;
`endif
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      heater_q    <= heater_d;
      center_q    <= center_d;
      locked_q    <= locked_d;
      busy_q      <= busy_d;
      skip_q      <= skip_d;
      rev_q       <= rev_d;
      move_q      <= move_d;
      pc_q        <= pc_d;
      pt_q        <= pt_d;
`ifdef RING_LOCK_SWEEP_EN
      best_code_q <= best_code_d;
      best_p_q    <= best_p_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    heater_d    = heater_q;
    center_d    = center_q;
    locked_d    = locked_q;
    skip_d      = skip_q;
    rev_d       = rev_q;
    move_d      = move_q;
    pc_d        = pc_q;
    pt_d        = pt_q;
    meas_start  = 1'b0;
    meas_abort  = 1'b0;
`ifdef RING_LOCK_SWEEP_EN
    best_code_d = best_code_q;
    best_p_d    = best_p_q;
`endif
    if (!enable) begin
      state_d    = ST_IDLE;
      locked_d   = 1'b0;
      skip_d     = 1'b0;
      rev_d      = '0;
      move_d     = '0;
      meas_abort = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          dir_d      = DIR_UP;
          rev_d      = '0;
          move_d     = '0;
          locked_d   = 1'b0;
          meas_start = 1'b1;
`ifdef RING_LOCK_SWEEP_EN
          state_d     = ST_SWEEP;
          heater_d    = '0;
          best_code_d = '0;
          best_p_d    = '1;
`else
          state_d  = ST_TRACK_CENTER;
          heater_d = INIT_VAL;
`endif
        end
`ifdef RING_LOCK_SWEEP_EN
        ST_SWEEP: begin
          locked_d = 1'b0;
          if (meas_done) begin
            if (meas_result < best_p_q) begin
              best_p_d    = meas_result;
              best_code_d = heater_q;
            end
            meas_start = 1'b1;
            if (sweep_next > HEATER_MAX) begin
              heater_d = best_code_d;
              dir_d    = DIR_UP;
              state_d  = ST_TRACK_CENTER;
            end else begin
              heater_d = sweep_next[HEATER_W-1:0];
            end
          end
        end
`endif
        ST_TRACK_CENTER: begin
          if (meas_done) begin
            pc_d     = meas_result;
            center_d = heater_q;
            state_d  = ST_TRACK_TRIAL;
            skip_d   = !trial_ok;
            if (trial_ok) begin
              heater_d   = trial_code;
              meas_start = 1'b1;
            end
          end
        end
        ST_TRACK_TRIAL: begin
          if (skip_q) begin
            state_d = ST_DECIDE;
          end else if (meas_done) begin
            pt_d    = meas_result;
            state_d = ST_DECIDE;
          end
        end
        ST_DECIDE: begin
          state_d    = ST_TRACK_CENTER;
          meas_start = 1'b1;
          if (!skip_q && (pt_q < pc_q)) begin
            rev_d  = '0;
            move_d = sat_inc(move_q);
            if (move_d == SAT_MAX) locked_d = 1'b0;
          end else begin
            heater_d = center_q;
            dir_d    = (dir_q == DIR_UP) ? DIR_DN : DIR_UP;
            move_d   = '0;
            rev_d    = sat_inc(rev_q);
            if (rev_d == SAT_MAX) locked_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  assign heater_code = heater_q;
  assign locked      = locked_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ring_heater_lock_ctrl.sv
// Scoreboard bench for ring_heater_lock_ctrl: a plant model answers heater codes with power,
// a reference model predicts the sequence of (heater_code, locked) changes.
module tb_ring_heater_lock_ctrl;
  localparam int unsigned HW     = 10;
  localparam int unsigned PW     = 12;
  localparam int unsigned SETTLE = 4;
  localparam int unsigned ALOG   = 1;
  localparam int unsigned STEP   = 256;
  localparam int unsigned INIT   = 512;
  localparam int          HMAX   = (1 << HW) - 1;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          enable    = 1'b0;
  logic          pd_valid  = 1'b0;
  logic [PW-1:0] pd_sample = '0;
  logic [HW-1:0] heater_code;
  logic          locked;
  logic          busy;

  ring_heater_lock_ctrl #(
    .HEATER_W     (HW),
    .PD_W         (PW),
    .SETTLE_CYCLES(SETTLE),
    .AVG_LOG2     (ALOG),
    .COARSE_STEP  (STEP),
    .INIT_CODE    (INIT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .pd_valid   (pd_valid),
    .pd_sample  (pd_sample),
    .heater_code(heater_code),
    .locked     (locked),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [HW-1:0] code;
    logic          lk;
  } ev_t;

  ev_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;

  int          target      = 700;
  bit          tie_mode    = 1'b0;
  bit          toggle_mode = 1'b0;
  int unsigned density     = 70;

  int m_code = INIT, m_dir = 1, m_rev = 0, m_move = 0;
  bit m_lk = 1'b0;
  int m_last_code = INIT;
  bit m_last_lk = 1'b0;

  function automatic int absd(int a, int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic int pw(int c);
    int a, b;
    if (tie_mode) begin
      a = absd(c, 256);
      b = absd(c, 768);
      return (a < b) ? a : b;
    end
    return absd(c, target);
  endfunction

  function automatic void emit(int c, bit l);
    ev_t e;
    if (c != m_last_code || l != m_last_lk) begin
      e.code = HW'(c);
      e.lk   = l;
      exp_q.push_back(e);
      m_last_code = c;
      m_last_lk   = l;
    end
  endfunction

  task automatic model_start();
    int best_c, best_p;
    m_dir  = 1;
    m_rev  = 0;
    m_move = 0;
    m_lk   = 1'b0;
    best_c = INIT;
    best_p = -1;
`ifdef RING_LOCK_SWEEP_EN
    for (int c = 0; c <= HMAX; c += STEP) begin
      emit(c, 1'b0);
      if (best_p < 0 || pw(c) < best_p) begin
        best_p = pw(c);
        best_c = c;
      end
    end
`endif
    m_code = best_c;
    emit(m_code, 1'b0);
  endtask

  task automatic model_run_to_lock();
    bit was, better;
    int t;
    for (int k = 0; k < 4000; k++) begin
      was    = m_lk;
      better = 1'b0;
      t      = m_code + m_dir;
      if (t >= 0 && t <= HMAX) begin
        emit(t, m_lk);
        better = (pw(t) < pw(m_code));
      end
      if (better) begin
        m_code = t;
        m_rev  = 0;
        if (m_move < 2) m_move++;
        if (m_move == 2) m_lk = 1'b0;
      end else begin
        m_move = 0;
        if (m_rev < 2) m_rev++;
        if (m_rev == 2) m_lk = 1'b1;
        m_dir = -m_dir;
      end
      emit(m_code, m_lk);
      if (!was && m_lk) break;
    end
  endtask

  task automatic check(input string what, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", what, act, req);
    end
  endtask

  task automatic wait_drain(input string what);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 25000) begin
      @(negedge clk); #1;
      cyc++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s: timeout, got %0d pending events, expected 0", what, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_disable(input string what);
    m_lk = 1'b0;
    emit(m_code, 1'b0);
    enable = 1'b0;
    @(posedge clk); #1;
    check({what, "_off_busy"},   int'(busy), 0);
    check({what, "_off_locked"}, int'(locked), 0);
    check({what, "_off_code"},   int'(heater_code), m_code);
    repeat (5) @(posedge clk);
    #1;
    check({what, "_hold_code"},  int'(heater_code), m_code);
  endtask

  task automatic do_enable(input string what);
    model_start();
    enable = 1'b1;
    @(posedge clk); #1;
    check({what, "_on_busy"}, int'(busy), 1);
  endtask

  // Plant: thru-port power of the current code, with junk while the ring is still settling.
  int            age     = 0;
  logic [HW-1:0] last_hc = HW'(INIT);
  bit            tog     = 1'b0;
  always @(negedge clk) begin
    #2;
    if (heater_code !== last_hc) begin
      age     = 0;
      last_hc = heater_code;
    end else if (age < 1000) begin
      age++;
    end
    tog      = ~tog;
    pd_valid = toggle_mode ? tog : ($urandom_range(0, 99) < density);
    if (age < int'(SETTLE) - 1 || !pd_valid) pd_sample = PW'($urandom_range(0, 4095));
    else                                     pd_sample = PW'(pw(int'(heater_code)));
  end

  logic [HW-1:0] mon_code = HW'(INIT);
  logic          mon_lk   = 1'b0;
  always @(negedge clk) begin
    ev_t e;
    if (!rst_n) begin
      mon_code = heater_code;
      mon_lk   = locked;
    end else if (heater_code !== mon_code || locked !== mon_lk) begin
      mon_code = heater_code;
      mon_lk   = locked;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (e.code !== heater_code || e.lk !== locked) begin
          n_err++;
          $display("FAIL event: got code=%0d locked=%0d, expected code=%0d locked=%0d",
                   heater_code, locked, e.code, e.lk);
        end
      end
    end
  end

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_code",   int'(heater_code), int'(INIT));
    check("rst_locked", int'(locked), 0);
    check("rst_busy",   int'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk); #1;

    target = 700; tie_mode = 1'b0; density = 70;
    do_enable("A");
    model_run_to_lock();
    wait_drain("lock700");
    check("lock700_code", int'(heater_code), 700);
    check("lock700_flag", int'(locked), 1);

    target = 705;
    model_run_to_lock();
    wait_drain("drift705");
    check("drift705_code", int'(heater_code), 705);
    check("drift705_flag", int'(locked), 1);

    toggle_mode = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    do_disable("C");

    toggle_mode = 1'b0; tie_mode = 1'b1;
    do_enable("D");
    model_run_to_lock();
    wait_drain("tie");
`ifdef RING_LOCK_SWEEP_EN
    check("tie_code", int'(heater_code), 256);
`else
    check("tie_code", int'(heater_code), 768);
`endif
    do_disable("D");

    tie_mode = 1'b0; target = 1100;
    do_enable("E");
    model_run_to_lock();
    wait_drain("edge1023");
    check("edge_code", int'(heater_code), HMAX);
    check("edge_flag", int'(locked), 1);
    do_disable("E");

    for (int r = 0; r < 2; r++) begin
      target  = int'($urandom_range(40, 1000));
      density = $urandom_range(30, 100);
      do_enable("F");
      model_run_to_lock();
      wait_drain("rand");
      check("rand_code", int'(heater_code), target);
      do_disable("F");
    end

    density = 80;
    do_enable("G");
    repeat (20) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_code",   int'(heater_code), int'(INIT));
    check("midrst_locked", int'(locked), 0);
    check("midrst_busy",   int'(busy), 0);
    exp_q.delete();
    m_last_code = INIT;
    m_last_lk   = 1'b0;
    enable      = 1'b0;
    repeat (2) @(posedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ring_heater_lock_ctrl.md
# ring_heater_lock_ctrl

Closed-loop controller that locks a resonant-ring modulator to the laser wavelength by driving the thermal tuner's heater code. It consumes averaged photodetector power samples taken at the ring's thru port downstream of the modulator. It runs an optional coarse sweep followed by continuous hill-climb tracking that minimises thru-port power. Its output feeds the heater DAC input of the thermal tuner.

## Interface
- HEATER_W, 10, heater DAC code width
- PD_W, 12, photodetector sample width (unsigned, larger = more power)
- SETTLE_CYCLES, 64, clk cycles to wait after every heater code change (thermal settling); must be ≥ 1
- AVG_LOG2, 2, log2 of the number of valid samples averaged per measurement
- COARSE_STEP, 16, code increment during the coarse sweep; must be ≥ 1
- INIT_CODE, 512, heater code at reset, and the track start point when the sweep is compiled out
- clk  in  1  controller clock
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  level; 1 = run lock loop, 0 = return to IDLE
- pd_valid  in  1  pd_sample is valid this cycle
- pd_sample  in  PD_W  thru-port power sample
- heater_code  out  HEATER_W  registered code to the thermal tuner
- locked  out  1  registered lock indicator
- busy  out  1  registered; 1 in any state except IDLE

## Operation
- States: IDLE, SWEEP, TRACK_CENTER, TRACK_TRIAL, DECIDE.
- Measurement, shared by all states: when heater_code changes, or on entry to a measuring state, wait SETTLE_CYCLES cycles and ignore pd_valid during the wait. Then accumulate 2^AVG_LOG2 samples where pd_valid=1. The accumulator is PD_W+AVG_LOG2 bits wide. Result = sum >> AVG_LOG2, truncated.
- IDLE: enable=1 → SWEEP if sweep is compiled in, else TRACK_CENTER with heater_code=INIT_CODE and dir=+1.
- SWEEP:
  - Measure codes 0, COARSE_STEP, 2·COARSE_STEP, … up to and including the largest value ≤ 2^HEATER_W−1.
  - Keep the minimum power and its code. Replace the minimum only on strictly-less, so ties keep the lower code.
  - At the end, set heater_code=best, dir=+1, and go to TRACK_CENTER.
- TRACK_CENTER: measure at heater_code and store as p_center. Then go to TRACK_TRIAL.
- TRACK_TRIAL:
  - If heater_code+dir is outside [0, 2^HEATER_W−1], skip the measurement and go to DECIDE with the outcome "worse".
  - Otherwise drive heater_code+dir and measure p_trial.
- DECIDE:
  - If p_trial < p_center: accept. heater_code keeps the trial value, dir is unchanged, rev_cnt=0, move_cnt++ (saturating at 2).
  - Otherwise: reject. Restore heater_code to the centre value, dir=−dir, rev_cnt++ (saturating at 2), move_cnt=0.
  - Then go to TRACK_CENTER.
- locked:
  - Set when rev_cnt reaches 2, i.e. two consecutive rejections.
  - Cleared when move_cnt reaches 2 (hysteresis).
  - Cleared in IDLE and SWEEP.
- enable=0 in any state: next cycle go to IDLE, abort any measurement and clear the accumulator and counters. heater_code holds its current value; locked=0; busy=0.
- Reset values: heater_code=INIT_CODE, locked=0, busy=0, state=IDLE, dir=+1, all counters 0.

## Timing
- All outputs are registered; state transitions take effect the cycle after the triggering condition.
- heater_code changes in the same cycle as entry to a measuring state. The settle counter starts that cycle.
- Minimum measurement latency = SETTLE_CYCLES + 2^AVG_LOG2 cycles (pd_valid=1 continuously). DECIDE takes 1 cycle.
- pd_valid gaps stretch the measurement; there is no timeout.
- A pd_valid arriving in the same cycle the accumulator reaches 2^AVG_LOG2 samples is not used.

## Configuration
- RING_LOCK_SWEEP_EN defined: SWEEP state, sweep counter and minimum registers are present; lock starts with the coarse sweep.
- Not defined: no SWEEP logic; enable goes IDLE → TRACK_CENTER from heater_code=INIT_CODE.

## Structure
- Package ring_lock_pkg: state enum, dir encoding, saturating-counter width constant.
- Sub-module ring_lock_meas: settle counter plus accumulator. Inputs: start, pd_valid, pd_sample, abort. Outputs: done (1-cycle pulse), result. The FSM instantiates it once.

## Test plan
Bench settings: SETTLE_CYCLES=4, AVG_LOG2=1, COARSE_STEP=256, HEATER_W=10.
- Reset mid-sweep: assert rst_n=0 → heater_code=512, locked=0, busy=0 immediately.
- Sweep with RING_LOCK_SWEEP_EN: power model |code−700| → 4 points measured (0, 256, 512, 768); sweep ends with heater_code=768 then tracks down to 700 → locked=1 after two rejections at 700.
- Tie in sweep: equal power at codes 256 and 768 → best=256.
- Boundary: start tracking at code 1023 with minimum above 1023 → trial skipped, dir reverses, no heater_code value 1024 ever driven; after both rejections, locked=1 at 1023.
- Drift: locked at 700, model minimum jumps to 705 → two accepted moves clear locked; relock at 705.
- pd_valid toggling every other cycle plus enable=0 mid-measurement → IDLE next cycle, heater_code held, busy=0; re-enable restarts cleanly.
